// File: rtl/bus_transfer_arbiter.sv
// Round-robin arbiter that sequences register-to-register transfers over the
// shared 32-bit datapath bus. Each granted transfer drives one bus source for
// a settling cycle, then pulses the destination load strobe while the source
// is still driven, then reports completion. An illegal source index is
// reported as an error without driving or loading anything.
//
// Ports:
//   clock_i    rising-edge clock
//   clear_i    synchronous active-high reset
//   req_i      per-requester level request, held until done
//   req_src_i  packed source indices, requester i at [5i+4:5i]
//   req_dst_i  packed destination indices, requester i at [5i+4:5i]
//   grant_o    one-hot owner of the current transfer
//   done_o     one-cycle completion pulse to the owner
//   err_o      one-cycle pulse with done_o when the source index was illegal
//   src_out_o  one-hot bus source strobe
//   dst_in_o   one-hot destination load strobe
//   busy_o     high whenever a transfer is in progress
module bus_transfer_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned SelW   = 5,
  parameter int unsigned NumSrc = 25,
  parameter int unsigned NumDst = 32
) (
  input  logic                   clock_i,
  input  logic                   clear_i,
  input  logic [NumReq-1:0]      req_i,
  input  logic [NumReq*SelW-1:0] req_src_i,
  input  logic [NumReq*SelW-1:0] req_dst_i,
  output logic [NumReq-1:0]      grant_o,
  output logic [NumReq-1:0]      done_o,
  output logic                   err_o,
  output logic [NumSrc-1:0]      src_out_o,
  output logic [NumDst-1:0]      dst_in_o,
  output logic                   busy_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  localparam logic [NumReq-1:0] ReqOne = NumReq'(1);
  localparam logic [NumSrc-1:0] SrcOne = NumSrc'(1);
  localparam logic [NumDst-1:0] DstOne = NumDst'(1);

  typedef enum logic [2:0] {StIdle, StDrive, StLoad, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [SelW-1:0]   src_q, src_d;
  logic [SelW-1:0]   dst_q, dst_d;

  logic [NumReq-1:0] grant_q, grant_d;
  logic [NumReq-1:0] done_q, done_d;
  logic              err_q, err_d;
  logic [NumSrc-1:0] src_out_q, src_out_d;
  logic [NumDst-1:0] dst_in_q, dst_in_d;
  logic              busy_q, busy_d;

  logic              found;
  logic [IdxW-1:0]   win;
  logic [IdxW-1:0]   cand;

  // Round-robin search starting at the pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = ptr_q + IdxW'(i);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    dst_d   = dst_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          idx_d   = win;
          src_d   = req_src_i[32'(win) * SelW +: SelW];
          dst_d   = req_dst_i[32'(win) * SelW +: SelW];
          state_d = (32'(src_d) < NumSrc) ? StDrive : StErr;
        end
      end
      StDrive: state_d = StLoad;
      StLoad:  state_d = StDone;
      StDone, StErr: begin
        ptr_d   = idx_q + IdxW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the upcoming state.
    busy_d    = (state_d != StIdle);
    grant_d   = busy_d ? (ReqOne << idx_d) : '0;
    done_d    = (state_d == StDone || state_d == StErr) ? (ReqOne << idx_d) : '0;
    err_d     = (state_d == StErr);
    src_out_d = (state_d == StDrive || state_d == StLoad) ? (SrcOne << src_d) : '0;
    dst_in_d  = (state_d == StLoad) ? (DstOne << dst_d) : '0;
  end

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      ptr_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      src_out_q <= '0;
      dst_in_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      src_out_q <= src_out_d;
      dst_in_q  <= dst_in_d;
      busy_q    <= busy_d;
    end
  end

  assign grant_o   = grant_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign src_out_o = src_out_q;
  assign dst_in_o  = dst_in_q;
  assign busy_o    = busy_q;

endmodule
